alu_pipe: RTL and testbench

- Parametrised, registered successor to the combinational CPU ALU.
- Adds a full 6502-style operation set, an N/V/Z/C flag output, and a valid/ready handshake on input and output.
- Adds optional BCD (decimal) adjust for ADC/SBC as a second cycle.
- Sits between the CPU operand/decode stage and the register-file/status-register writeback.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_pipe_bcd_adjust.sv | 47 ++++
 rtl/alu_pipe.sv | 174 +++++++++++++++++
 tb/tb_alu_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined 6502-style ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        ADC   = 4'd0,
        SBC   = 4'd1,
        AND   = 4'd2,
        ORA   = 4'd3,
        EOR   = 4'd4,
        ASL   = 4'd5,
        LSR   = 4'd6,
        ROL   = 4'd7,
        ROR   = 4'd8,
        CMP   = 4'd9,
        INC   = 4'd10,
        DEC   = 4'd11,
        PASSB = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADJ  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    localparam int FLG_N = 3;
    localparam int FLG_V = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_C = 0;

    // Only the arithmetic ops have a decimal form.
    function automatic logic is_bcd_op(input alu_op_t o);
        return (o == ADC) || (o == SBC);
    endfunction

endpackage

// File: rtl/alu_pipe_bcd_adjust.sv
// Combinational decimal correction of a binary ADC/SBC result, nibble by nibble.
module bcd_adjust #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   bin_res,
    input  logic [WIDTH/4-1:0] nib_carry,
    input  logic               is_sub,
    output logic [WIDTH-1:0]   adj_res,
    output logic               adj_carry
);

    localparam int NIB = WIDTH / 4;

    logic [4:0] n5_s;
    logic       prop_s;

    // Binary carries already moved between nibbles; only the +6 overflow propagates on add.
    always_comb begin
        adj_res = {WIDTH{1'b0}};
        n5_s    = 5'd0;
        prop_s  = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            if (is_sub) begin
                if (!nib_carry[i]) begin
                    adj_res[4*i+:4] = bin_res[4*i+:4] - 4'd6;
                end else begin
                    adj_res[4*i+:4] = bin_res[4*i+:4];
                end
            end else begin
                n5_s = {1'b0, bin_res[4*i+:4]} + {4'd0, prop_s};
                if ((n5_s > 5'd9) || nib_carry[i]) begin
                    n5_s = n5_s + 5'd6;
                end else begin
                    n5_s = n5_s;
                end
                adj_res[4*i+:4] = n5_s[3:0];
                prop_s          = n5_s[4];
            end
        end
        if (is_sub) begin
            adj_carry = nib_carry[NIB-1];
        end else begin
            adj_carry = prop_s | nib_carry[NIB-1];
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered 6502-style ALU with valid/ready handshake and optional second-cycle BCD adjust.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic             carry_in,
    input  logic             dec_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags_out
);

    localparam int NIB = WIDTH / 4;

    alu_op_t          op_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             add_cin_s;
    logic [4:0]       nib_sum_s;
    logic             chain_s;
    logic [WIDTH-1:0] add_res_s;
    logic [NIB-1:0]   nib_c_s;
    logic             add_c_s;
    logic             add_v_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             v_s;
    logic             undef_s;
    logic [3:0]       bin_flags_s;
    logic             is_dec_s;
    logic             xfer_s;
    logic [WIDTH-1:0] adj_res_s;
    logic             adj_c_s;

    alu_state_t       state_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] alu_out_r;
    logic [3:0]       flags_r;
    logic [NIB-1:0]   nib_c_r;
    logic             is_sub_r;

    assign op_s = alu_op_t'(op);

    // Nibble-ripple adder shared by ADC, SBC and CMP; exposes per-nibble carries for BCD.
    always_comb begin
        if ((op_s == SBC) || (op_s == CMP)) begin
            b_eff_s = ~alu_b;
        end else begin
            b_eff_s = alu_b;
        end
        if (op_s == CMP) begin
            add_cin_s = 1'b1;
        end else begin
            add_cin_s = carry_in;
        end
        nib_sum_s = 5'd0;
        chain_s   = add_cin_s;
        add_res_s = {WIDTH{1'b0}};
        nib_c_s   = {NIB{1'b0}};
        for (int i = 0; i < NIB; i++) begin
            nib_sum_s = {1'b0, alu_a[4*i+:4]} + {1'b0, b_eff_s[4*i+:4]} + {4'd0, chain_s};
            add_res_s[4*i+:4] = nib_sum_s[3:0];
            chain_s    = nib_sum_s[4];
            nib_c_s[i] = nib_sum_s[4];
        end
        add_c_s = nib_c_s[NIB-1];
        add_v_s = (alu_a[WIDTH-1] == b_eff_s[WIDTH-1]) && (add_res_s[WIDTH-1] != alu_a[WIDTH-1]);
    end

    // Operation select and binary-stage flags.
    always_comb begin
        res_s   = alu_b;
        c_s     = carry_in;
        v_s     = 1'b0;
        undef_s = 1'b0;
        case (op_s)
            ADC, SBC: begin res_s = add_res_s; c_s = add_c_s; v_s = add_v_s; end
            AND:      res_s = alu_a & alu_b;
            ORA:      res_s = alu_a | alu_b;
            EOR:      res_s = alu_a ^ alu_b;
            ASL:      begin res_s = {alu_a[WIDTH-2:0], 1'b0};     c_s = alu_a[WIDTH-1]; end
            LSR:      begin res_s = {1'b0, alu_a[WIDTH-1:1]};     c_s = alu_a[0];       end
            ROL:      begin res_s = {alu_a[WIDTH-2:0], carry_in}; c_s = alu_a[WIDTH-1]; end
            ROR:      begin res_s = {carry_in, alu_a[WIDTH-1:1]}; c_s = alu_a[0];       end
            CMP:      begin res_s = add_res_s; c_s = add_c_s; end
            INC:      res_s = alu_a + {{(WIDTH-1){1'b0}}, 1'b1};
            DEC:      res_s = alu_a - {{(WIDTH-1){1'b0}}, 1'b1};
            PASSB:    res_s = alu_b;
            default:  begin res_s = alu_b; undef_s = 1'b1; end
        endcase
        if (undef_s) begin
            bin_flags_s = 4'b0000;
        end else begin
            bin_flags_s = {res_s[WIDTH-1], v_s, (res_s == {WIDTH{1'b0}}), c_s};
        end
    end

    assign is_dec_s = DECIMAL_EN && dec_in && is_bcd_op(op_s);
    assign in_ready = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign xfer_s   = in_valid && in_ready;

    bcd_adjust #(.WIDTH(WIDTH)) u_bcd (
        .bin_res   (alu_out_r),
        .nib_carry (nib_c_r),
        .is_sub    (is_sub_r),
        .adj_res   (adj_res_s),
        .adj_carry (adj_c_s)
    );

    // Handshake FSM and result registers; V survives the adjust cycle from the binary stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            alu_out_r   <= {WIDTH{1'b0}};
            flags_r     <= 4'b0000;
            nib_c_r     <= {NIB{1'b0}};
            is_sub_r    <= 1'b0;
        end else if (xfer_s) begin
            alu_out_r <= res_s;
            flags_r   <= bin_flags_s;
            nib_c_r   <= nib_c_s;
            is_sub_r  <= (op_s == SBC);
            if (is_dec_s) begin
                state_r     <= ADJ;
                out_valid_r <= 1'b0;
            end else begin
                state_r     <= DONE;
                out_valid_r <= 1'b1;
            end
        end else begin
            case (state_r)
                ADJ: begin
                    alu_out_r   <= adj_res_s;
                    flags_r     <= {adj_res_s[WIDTH-1], flags_r[FLG_V],
                                    (adj_res_s == {WIDTH{1'b0}}), adj_c_s};
                    state_r     <= DONE;
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                IDLE: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign alu_out   = alu_out_r;
    assign flags_out = flags_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized self-checking bench for alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       carry_in;
    logic       dec_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_out;
    logic [3:0] flags_out;

    int vectors     = 0;
    int miscompares = 0;

    alu_pipe #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .carry_in  (carry_in),
        .dec_in    (dec_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .flags_out (flags_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int to_dec(input int v);
        return (v / 16) * 10 + (v % 16);
    endfunction

    // Reference model in plain integer arithmetic; returns {res, N, V, Z, C}.
    function automatic void model(input int o, input int a, input int b, input int c,
                                  input int d, output logic [7:0] r, output logic [3:0] f);
        int t, sa, sb, cc, v, dt;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        cc = c;
        v  = 0;
        t  = 0;
        case (o)
            0:  begin t = a + b + c; cc = (t > 255) ? 1 : 0;
                      dt = sa + sb + c; v = (dt > 127 || dt < -128) ? 1 : 0; end
            1:  begin t = a - b - 1 + c; cc = (t >= 0) ? 1 : 0;
                      dt = sa - sb - 1 + c; v = (dt > 127 || dt < -128) ? 1 : 0; end
            2:  t = a & b;
            3:  t = a | b;
            4:  t = a ^ b;
            5:  begin t = a * 2; cc = a / 128; end
            6:  begin t = a / 2; cc = a % 2; end
            7:  begin t = a * 2 + c; cc = a / 128; end
            8:  begin t = a / 2 + c * 128; cc = a % 2; end
            9:  begin t = a - b; cc = (a >= b) ? 1 : 0; end
            10: t = a + 1;
            11: t = a + 255;
            12: t = b;
            default: begin r = 8'(b); f = 4'b0000; return; end
        endcase
        if (d != 0 && (o == 0 || o == 1)) begin
            if (o == 0) begin
                dt = to_dec(a) + to_dec(b) + c;
                cc = (dt >= 100) ? 1 : 0;
                dt = dt % 100;
            end else begin
                dt = to_dec(a) - to_dec(b) - 1 + c;
                cc = (dt >= 0) ? 1 : 0;
                if (dt < 0) dt = dt + 100;
            end
            t = (dt / 10) * 16 + (dt % 10);
        end
        r = 8'(t);
        f = {r[7], v[0], (r == 8'h00), cc[0]};
    endfunction

    // One transaction with out_ready held high; checks 1- or 2-cycle latency and result.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic c, input logic d);
        logic [7:0] er;
        logic [3:0] ef;
        model(int'(o), int'(a), int'(b), int'(c), int'(d), er, ef);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        op = o; alu_a = a; alu_b = b; carry_in = c; dec_in = d;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_a = ~a; alu_b = ~b;
        if (d && (o == 4'd0 || o == 4'd1)) begin
            chk({tag, ".adj_valid"}, 32'(out_valid), 32'd0);
            chk({tag, ".adj_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out"}, 32'(alu_out), 32'(er));
        chk({tag, ".flags"}, 32'(flags_out), 32'(ef));
    endtask

    initial begin
        logic [3:0] ro;
        logic [7:0] ra, rb;
        logic       rc, rd;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0;
        alu_a = 8'h00; alu_b = 8'h00; carry_in = 1'b0; dec_in = 1'b0;
        #12;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.out", 32'(alu_out), 32'd0);
        chk("rst.flags", 32'(flags_out), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rel.in_ready", 32'(in_ready), 32'd1);
        chk("rel.valid", 32'(out_valid), 32'd0);

        run_op("adc_ovf", 4'd0, 8'h50, 8'h50, 1'b0, 1'b0);
        chk("adc_ovf.const", 32'({alu_out, flags_out}), 32'({8'hA0, 4'b1100}));
        run_op("sbc_brw", 4'd1, 8'h00, 8'h01, 1'b1, 1'b0);
        chk("sbc_brw.const", 32'({alu_out, flags_out}), 32'({8'hFF, 4'b1000}));
        run_op("cmp_eq", 4'd9, 8'h40, 8'h40, 1'b0, 1'b0);
        chk("cmp_eq.const", 32'({alu_out, flags_out}), 32'({8'h00, 4'b0011}));
        run_op("dadc", 4'd0, 8'h58, 8'h46, 1'b1, 1'b1);
        chk("dadc.const", 32'({alu_out, flags_out[0]}), 32'({8'h05, 1'b1}));
        run_op("dsbc", 4'd1, 8'h46, 8'h12, 1'b1, 1'b1);
        chk("dsbc.const", 32'({alu_out, flags_out[0]}), 32'({8'h34, 1'b1}));
        run_op("ror", 4'd8, 8'h01, 8'h00, 1'b1, 1'b0);
        chk("ror.const", 32'({alu_out, flags_out}), 32'({8'h80, 4'b1001}));
        run_op("asl", 4'd5, 8'h80, 8'h00, 1'b0, 1'b0);
        chk("asl.const", 32'({alu_out, flags_out}), 32'({8'h00, 4'b0011}));
        run_op("undef", 4'd14, 8'h12, 8'h00, 1'b1, 1'b0);

        // Backpressure: result held while out_ready is low, then back-to-back accept.
        op = 4'd2; alu_a = 8'hF0; alu_b = 8'h3C; carry_in = 1'b0; dec_in = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        op = 4'd12; alu_b = 8'h77;
        chk("bp.out", 32'(alu_out), 32'h30);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp.hold_out", 32'(alu_out), 32'h30);
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
        end
        op = 4'd4; alu_a = 8'hFF; alu_b = 8'h0F; carry_in = 1'b1; out_ready = 1'b1;
        #1 chk("b2b.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b.out", 32'(alu_out), 32'hF0);
        chk("b2b.flags", 32'(flags_out), 32'b1001);
        @(posedge clk); #1;
        chk("b2b.drain", 32'(out_valid), 32'd0);

        // Reset while the decimal adjust is pending.
        op = 4'd0; alu_a = 8'h58; alu_b = 8'h46; carry_in = 1'b1; dec_in = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("radj.adj_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("radj.valid", 32'(out_valid), 32'd0);
        chk("radj.flags", 32'(flags_out), 32'd0);
        chk("radj.out", 32'(alu_out), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("radj.in_ready", 32'(in_ready), 32'd1);
        chk("radj.stale", 32'(out_valid), 32'd0);

        // Randomized ops; decimal ops use valid BCD operands.
        for (int n = 0; n < 300; n++) begin
            ro = 4'($urandom_range(0, 15));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (rd && (ro == 4'd0 || ro == 4'd1)) begin
                ra = 8'($urandom_range(0, 9) * 16 + $urandom_range(0, 9));
                rb = 8'($urandom_range(0, 9) * 16 + $urandom_range(0, 9));
            end
            run_op("rand", ro, ra, rb, rc, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
